// File: rtl/id_decode_ctrl_pkg.sv
// Shared decode constants: opcodes, immediate-type codes, controller states,
// buffer depth and the per-entry storage layout.
// Macro ID_IMM_PRECOMP_EN adds a precomputed 32-bit immediate to each entry.
package id_decode_ctrl_pkg;

  localparam int unsigned BUF_DEPTH = 2;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // Occupancy states; width covers 0..BUF_DEPTH entries.
  typedef enum logic [$clog2(BUF_DEPTH+1)-1:0] {
    EMPTY,
    ONE,
    TWO
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    imm_type_e   imm_type;
    logic        illegal;
`ifdef ID_IMM_PRECOMP_EN
    logic [31:0] imm;
`endif
  } entry_t;

`ifdef ID_IMM_PRECOMP_EN
  // RV32I immediate operand expansion.
  function automatic logic [31:0] imm_expand(input logic [31:0] i, input imm_type_e t);
    logic [31:0] r;
    case (t)
      IMM_I:   r = {{20{i[31]}}, i[31:20]};
      IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   r = {i[31:12], 12'b0};
      IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction
`endif

endpackage

// File: rtl/id_decode_ctrl_imm_type_decode.sv
// Combinational opcode decode: immediate-type code and illegal flag.
module imm_type_decode
  import id_decode_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_type,
  output logic       illegal
);

  // Map opcode to immediate type; anything unrecognised (including a
  // non-11 low quadrant) is illegal with no immediate.
  always_comb begin
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm_type = IMM_I;
      OP_STORE:                 imm_type = IMM_S;
      OP_BRANCH:                imm_type = IMM_B;
      OP_LUI, OP_AUIPC:         imm_type = IMM_U;
      OP_JAL:                   imm_type = IMM_J;
      OP_REG:                   imm_type = IMM_NONE;
      default:                  illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_decode_ctrl.sv
// ID-stage controller: 2-entry in-order skid buffer between IF and EX.
// Type/illegal decode happens at enqueue and travels with each entry.
// Macro ID_IMM_PRECOMP_EN: also expand and store the immediate per entry;
// otherwise id_imm is tied to zero.
module id_decode_ctrl
  import id_decode_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [2:0]  id_imm_type,
  output logic        id_illegal,
  output logic [31:0] id_imm
);

  state_e     state;
  entry_t     head;
  entry_t     tail;
  entry_t     new_ent;
  logic [2:0] dec_type;
  logic       dec_ill;
  logic       in_fire;
  logic       out_fire;

  imm_type_decode u_dec (
    .opcode   (if_instr[6:0]),
    .imm_type (dec_type),
    .illegal  (dec_ill)
  );

  // Handshakes decode from registered state only.
  assign if_ready = (state != TWO);
  assign id_valid = (state != EMPTY);
  assign in_fire  = if_valid & if_ready;
  assign out_fire = id_valid & ex_ready;

  // Assemble the entry for the offered instruction.
  always_comb begin
    new_ent          = '0;
    new_ent.instr    = if_instr;
    new_ent.pc       = if_pc;
    new_ent.imm_type = imm_type_e'(dec_type);
    new_ent.illegal  = dec_ill;
`ifdef ID_IMM_PRECOMP_EN
    new_ent.imm      = imm_expand(if_instr, imm_type_e'(dec_type));
`endif
  end

  // Occupancy FSM; head is the output register and is left untouched when
  // the buffer drains so id_* hold their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= EMPTY;
      head          <= '0;
      head.imm_type <= IMM_NONE;
      tail          <= '0;
      tail.imm_type <= IMM_NONE;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            head  <= new_ent;
            state <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head <= new_ent;
          end else if (in_fire) begin
            tail  <= new_ent;
            state <= TWO;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign id_instr    = head.instr;
  assign id_pc       = head.pc;
  assign id_imm_type = head.imm_type;
  assign id_illegal  = head.illegal;
`ifdef ID_IMM_PRECOMP_EN
  assign id_imm      = head.imm;
`else
  assign id_imm      = '0;
`endif

endmodule

// File: tb/tb_id_decode_ctrl.sv
// Testbench for id_decode_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_id_decode_ctrl;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        ex_ready;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  id_imm_type;
  logic        id_illegal;
  logic [31:0] id_imm;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];

  id_decode_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_ready    (if_ready),
    .ex_ready    (ex_ready),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_imm_type (id_imm_type),
    .id_illegal  (id_illegal),
    .id_imm      (id_imm)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] m_type(input logic [31:0] w);
    case (w[6:0])
      7'h13, 7'h03, 7'h67: return T_I;
      7'h23:               return T_S;
      7'h63:               return T_B;
      7'h37, 7'h17:        return T_U;
      7'h6F:               return T_J;
      default:             return T_NONE;
    endcase
  endfunction

  function automatic logic m_ill(input logic [31:0] w);
    return (m_type(w) == T_NONE) && (w[6:0] != 7'h33);
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] w);
    logic [31:0] s;
    logic [31:0] r;
    s = {32{w[31]}};
    case (m_type(w))
      T_I:     r = $signed(w) >>> 20;
      T_S:     r = (s << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
      T_B:     r = (s << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      T_U:     r = w & 32'hFFFF_F000;
      T_J:     r = (s << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: r = 32'h0;
    endcase
`ifdef ID_IMM_PRECOMP_EN
    return r;
`else
    return (r & 32'h0);
`endif
  endfunction

  // Advance one clock and update the occupancy model from the driven inputs.
  task automatic tick();
    bit inf, outf;
    inf  = if_valid && (q.size() < 2) && !flush;
    outf = (q.size() > 0) && ex_ready;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back('{instr: if_instr, pc: if_pc});
    end
    #1;
  endtask

  task automatic idle();
    if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0; ex_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", id_pc); end
    checks++; if (id_imm_type !== T_NONE) begin errors++; $display("FAIL rst_type got %0d want %0d", id_imm_type, T_NONE); end
    checks++; if (id_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %0b want 0", id_illegal); end
    checks++; if (id_imm !== 32'h0) begin errors++; $display("FAIL rst_imm got %h want 0", id_imm); end
    rst = 1'b0;
    q.delete();
    tick();
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL rst_if_ready got %0b want 1", if_ready); end
  endtask

  task automatic test_addi();
    idle();
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h100;
    tick();
    if_valid = 1'b0;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b want 1", id_valid); end
    checks++; if (id_imm_type !== T_I) begin errors++; $display("FAIL addi_type got %0d want %0d", id_imm_type, T_I); end
    checks++; if (id_illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal got %0b want 0", id_illegal); end
    checks++; if (id_imm !== m_imm(32'h00500093)) begin errors++; $display("FAIL addi_imm got %h want %h", id_imm, m_imm(32'h00500093)); end
    checks++; if (id_pc !== 32'h100) begin errors++; $display("FAIL addi_pc got %h want 100", id_pc); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %0b want 0", id_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    w[0] = 32'h00100113; w[1] = 32'h00200193; w[2] = 32'h00300213;
    idle();
    if_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if_instr = w[i]; if_pc = 32'h200 + 32'(i * 4);
      tick();
    end
    if_instr = w[2]; if_pc = 32'h208;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %0b want 0", if_ready); end
    tick();
    checks++; if (id_instr !== w[0] || if_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got %h/%0b want %h/0", id_instr, if_ready, w[0]); end
    ex_ready = 1'b1;
    tick();
    checks++; if (id_instr !== w[1] || if_ready !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%0b want %h/1", id_instr, if_ready, w[1]); end
    tick();
    if_valid = 1'b0;
    checks++; if (id_instr !== w[2] || id_pc !== 32'h208 || id_valid !== 1'b1) begin errors++; $display("FAIL b2b_third got %h/%h want %h/208", id_instr, id_pc, w[2]); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", id_valid); end
  endtask

  task automatic test_branch_jal();
    idle();
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'hFE000EE3; if_pc = 32'h300;
    tick();
    if_instr = 32'h008000EF; if_pc = 32'h304;
    checks++; if (id_imm_type !== T_B || id_imm !== m_imm(32'hFE000EE3)) begin errors++; $display("FAIL beq got %0d/%h want %0d/%h", id_imm_type, id_imm, T_B, m_imm(32'hFE000EE3)); end
`ifdef ID_IMM_PRECOMP_EN
    checks++; if (id_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_const got %h want fffffffc", id_imm); end
`endif
    tick();
    if_valid = 1'b0;
    checks++; if (id_imm_type !== T_J || id_imm !== m_imm(32'h008000EF)) begin errors++; $display("FAIL jal got %0d/%h want %0d/%h", id_imm_type, id_imm, T_J, m_imm(32'h008000EF)); end
`ifdef ID_IMM_PRECOMP_EN
    checks++; if (id_imm !== 32'h00000008) begin errors++; $display("FAIL jal_const got %h want 8", id_imm); end
`endif
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] w [3];
    logic [2:0]  et [3];
    logic        ei [3];
    w[0] = 32'h00000000; et[0] = T_NONE; ei[0] = 1'b1;
    w[1] = 32'h002081B3; et[1] = T_NONE; ei[1] = 1'b0;
    w[2] = 32'h00500090; et[2] = T_NONE; ei[2] = 1'b1;
    idle();
    ex_ready = 1'b1; if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_instr = w[i];
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_illegal !== ei[i] || id_imm_type !== et[i] || id_imm !== 32'h0)
        begin errors++; $display("FAIL illegal_%0d got v%0b i%0b t%0d m%h want v1 i%0b t%0d m0", i, id_valid, id_illegal, id_imm_type, id_imm, ei[i], et[i]); end
    end
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    idle();
    if_valid = 1'b1; if_instr = 32'h00100093;
    repeat (2) tick();
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL flush_pre got %0b want 0", if_ready); end
    flush = 1'b1; ex_ready = 1'b1; if_instr = 32'hDEAD0013;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    checks++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin errors++; $display("FAIL flush_two got v%0b r%0b want v0 r1", id_valid, if_ready); end
    // Flush while ONE with an acceptable offer: offer must be dropped.
    if_valid = 1'b1; if_instr = 32'h00700093; ex_ready = 1'b0;
    tick();
    flush = 1'b1; ex_ready = 1'b1; if_instr = 32'hBEEF0013;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_%0d got %0b/%h want 0", i, id_valid, id_instr); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    idle();
    if_valid = 1'b1; if_instr = 32'h00900093;
    repeat (2) tick();
    if_valid = 1'b0;
    checks++; if (id_valid !== 1'b1 || if_ready !== 1'b0) begin errors++; $display("FAIL arst_pre got v%0b r%0b want v1 r0", id_valid, if_ready); end
    #2 rst = 1'b1;
    #1;
    q.delete();
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL arst_now got v%0b %h want v0 0", id_valid, id_instr); end
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    checks++; if (if_ready !== 1'b1 || id_valid !== 1'b0) begin errors++; $display("FAIL arst_after got r%0b v%0b want r1 v0", if_ready, id_valid); end
  endtask

  task automatic test_random();
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
    idle();
    for (int n = 0; n < 600; n++) begin
      r = $urandom();
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      if_instr = {r[31:7], ops[$urandom_range(0, 9)]};
      if ($urandom_range(0, 9) == 0) if_instr = r;
      if_pc    = $urandom();
      tick();
      checks++; if (if_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", n, if_ready, q.size() < 2); end
      checks++; if (id_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", n, id_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++;
        if (id_instr !== q[0].instr || id_pc !== q[0].pc || id_imm_type !== m_type(q[0].instr)
            || id_illegal !== m_ill(q[0].instr) || id_imm !== m_imm(q[0].instr))
          begin errors++; $display("FAIL rnd_head cyc %0d got %h %h t%0d i%0b %h want %h %h t%0d i%0b %h", n,
            id_instr, id_pc, id_imm_type, id_illegal, id_imm, q[0].instr, q[0].pc, m_type(q[0].instr), m_ill(q[0].instr), m_imm(q[0].instr)); end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch_jal();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
